// File: rtl/uart_8250_pkg.sv
// Shared definitions for the uart_8250 responder and its Wishbone byte-path master:
// register offsets, LSR bit positions, master FSM states and a lane-select helper.
package uart_8250_pkg;

    // Register byte offsets inside the 16-byte UART window
    localparam logic [3:0] REG_RHR_THR = 4'd0;
    localparam logic [3:0] REG_IER     = 4'd1;
    localparam logic [3:0] REG_IIR_FCR = 4'd2;
    localparam logic [3:0] REG_LCR     = 4'd3;
    localparam logic [3:0] REG_MCR     = 4'd4;
    localparam logic [3:0] REG_LSR     = 4'd5;
    localparam logic [3:0] REG_MSR     = 4'd6;

    // Line status register bit indices
    localparam int LSR_DR   = 0;
    localparam int LSR_THRE = 5;

    // Byte-path master states
    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_IDLE,
        ST_GAP,
        ST_LSR_RD,
        ST_RHR_RD,
        ST_THR_WR
    } wbm_state_t;

    // One-hot byte select for a byte lane within the 32-bit data bus
    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/wb_single_access.sv
// Single classic Wishbone access engine: launches one byte read or write to
// BASE + offset, steers the byte onto / off the correct lane, and reports
// completion. With UART_WBM_TIMEOUT_EN defined an ACK-wait counter aborts an
// access that is not acknowledged within TIMEOUT_CYCLES cycles.
module wb_single_access
    import uart_8250_pkg::*;
#(
    parameter logic [31:0] BASE           = 32'h1250_0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  offset,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  rdata,
    output logic [31:0] adr,
    output logic [31:0] dat_w,
    output logic [3:0]  sel,
    output logic        we_bus,
    output logic        stb,
    output logic        cyc,
    input  logic [31:0] dat_r,
    input  logic        ack
);

    logic [1:0] lane;

    // Completion is seen on the ACK edge itself so the caller can change state
    // on that same edge; ACK while no access is active is ignored.
    assign done  = stb && ack;
    assign rdata = dat_r[{lane, 3'b000} +: 8];

    // Bus output registers: launch when idle and requested, drop on ACK or abort.
    // Address, data and select stay put after the access so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb    <= 1'b0;
            cyc    <= 1'b0;
            adr    <= '0;
            dat_w  <= '0;
            sel    <= '0;
            we_bus <= 1'b0;
            lane   <= '0;
        end else if (stb) begin
            if (done || timeout) begin
                stb <= 1'b0;
                cyc <= 1'b0;
            end
        end else if (start) begin
            stb    <= 1'b1;
            cyc    <= 1'b1;
            adr    <= BASE + {28'd0, offset};
            sel    <= lane_sel(offset[1:0]);
            dat_w  <= we ? ({24'd0, wdata} << {offset[1:0], 3'b000}) : 32'd0;
            we_bus <= we;
            lane   <= offset[1:0];
        end
    end

`ifdef UART_WBM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counts cycles spent with STB high and no ACK; cleared whenever STB is low.
    always_ff @(posedge clk) begin
        if (rst || !stb || ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Abort on the edge that ends the TIMEOUT_CYCLES-th unacknowledged cycle
    assign timeout = stb && !ack && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/uart_8250_wb_master.sv
// Wishbone initiator giving a CPU-less byte path into and out of a uart_8250.
// Programs LCR once after reset, then polls LSR; moves bytes from the tx
// stream into THR and from RHR into the rx stream.
// Optional feature macro: UART_WBM_TIMEOUT_EN (ACK timeout with err pulse).
module uart_8250_wb_master
    import uart_8250_pkg::*;
#(
    parameter logic [31:0] UART_BASE      = 32'h1250_0000,
    parameter logic [7:0]  LCR_INIT       = 8'h03,
    parameter int          POLL_GAP       = 4,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        WE_O,
    output logic [3:0]  SEL_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic        ACK_I,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        err
);

    wbm_state_t state, state_next;

    logic [7:0] gap_cnt;
    logic       tx_full;
    logic [7:0] tx_hold;

    logic       req;
    logic [3:0] req_offset;
    logic [7:0] req_wdata;
    logic       req_we;
    logic       done;
    logic       timeout;
    logic [7:0] rdata;

    wb_single_access #(
        .BASE           (UART_BASE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_access (
        .clk     (CLK_I),
        .rst     (RST_I),
        .start   (req),
        .offset  (req_offset),
        .wdata   (req_wdata),
        .we      (req_we),
        .done    (done),
        .timeout (timeout),
        .rdata   (rdata),
        .adr     (ADR_O),
        .dat_w   (DAT_O),
        .sel     (SEL_O),
        .we_bus  (WE_O),
        .stb     (STB_O),
        .cyc     (CYC_O),
        .dat_r   (DAT_I),
        .ack     (ACK_I)
    );

    // State register
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= ST_INIT_WR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and access request decode; rdata carries LSR on the LSR ACK edge
    always_comb begin
        state_next = state;
        req        = 1'b0;
        req_offset = REG_LSR;
        req_wdata  = 8'd0;
        req_we     = 1'b0;
        unique case (state)
            ST_INIT_WR: begin
                req        = 1'b1;
                req_offset = REG_LCR;
                req_wdata  = LCR_INIT;
                req_we     = 1'b1;
                // A timed-out LCR write is simply reissued: polling is
                // pointless until the line format has been programmed.
                if (done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_next = ST_LSR_RD;
            end
            ST_GAP: begin
                if (gap_cnt == 8'(POLL_GAP - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_LSR_RD: begin
                req        = 1'b1;
                req_offset = REG_LSR;
                if (done) begin
                    if (rdata[LSR_DR] && !rx_valid) begin
                        state_next = ST_RHR_RD;
                    end else if (rdata[LSR_THRE] && tx_full) begin
                        state_next = ST_THR_WR;
                    end else begin
                        state_next = ST_GAP;
                    end
                end else if (timeout) begin
                    state_next = ST_GAP;
                end
            end
            ST_RHR_RD: begin
                req        = 1'b1;
                req_offset = REG_RHR_THR;
                if (done) begin
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    state_next = ST_GAP;
                end
            end
            ST_THR_WR: begin
                req        = 1'b1;
                req_offset = REG_RHR_THR;
                req_wdata  = tx_hold;
                req_we     = 1'b1;
                if (done) begin
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    state_next = ST_GAP;
                end
            end
            default: begin
                state_next = ST_INIT_WR;
            end
        endcase
    end

    // Idle-cycle counter between polls that found nothing to do
    always_ff @(posedge CLK_I) begin
        if (RST_I || state != ST_GAP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 8'd1;
        end
    end

    // Nothing is accepted until LCR is programmed, and never while a byte is held
    assign tx_ready = !tx_full && (state != ST_INIT_WR);

    // One-entry transmit holding register; emptied only by a completed THR write
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            tx_full <= 1'b0;
            tx_hold <= 8'd0;
        end else if (state == ST_THR_WR && done) begin
            tx_full <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            tx_full <= 1'b1;
            tx_hold <= tx_data;
        end
    end

    // Receive output register; RHR is never read while it is occupied
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'd0;
        end else if (state == ST_RHR_RD && done) begin
            rx_valid <= 1'b1;
            rx_data  <= rdata;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef UART_WBM_TIMEOUT_EN
    // One-cycle error pulse following an aborted access
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            err <= 1'b0;
        end else begin
            err <= timeout;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/uart_8250_wb_master.md
# uart_8250_wb_master

Wishbone initiator that drives a `uart_8250` register-mapped responder on the same bus. It serves as the CPU-less byte path into and out of the UART. It programs the line control once after reset, then polls LSR. It moves bytes from a valid/ready transmit stream into THR, and from RHR into a valid/ready receive stream. It sits between on-chip byte producers/consumers and the UART's Wishbone slave port.

## Interface
- `UART_BASE`, 32'h1250_0000, base address of the UART register window (16-byte aligned)
- `LCR_INIT`, 8'h03, value written to LCR (offset 3) after reset (8N1)
- `POLL_GAP`, 4, idle cycles between LSR polls that find no work (1..255)
- `TIMEOUT_CYCLES`, 64, ACK wait limit (used only with the timeout feature)
- `CLK_I` in 1: clock, all logic on rising edge
- `RST_I` in 1: synchronous, active-high reset
- `ADR_O` out 32: `UART_BASE` + register byte offset
- `DAT_O` out 32: write data, byte placed in lane `offset[1:0]`
- `DAT_I` in 32: read data, byte taken from lane `offset[1:0]`
- `WE_O` out 1: write enable
- `SEL_O` out 4: one-hot byte select, bit `offset[1:0]`
- `STB_O`, `CYC_O` out 1: strobe and cycle, always driven together
- `ACK_I` in 1: slave acknowledge
- `tx_data` in 8, `tx_valid` in 1, `tx_ready` out 1: transmit byte stream
- `rx_data` out 8, `rx_valid` out 1, `rx_ready` in 1: receive byte stream
- `err` out 1: one-cycle pulse on bus timeout

## Operation
- FSM states: INIT_WR, IDLE, GAP, LSR_RD, RHR_RD, THR_WR.
- **INIT_WR:** write `LCR_INIT` to offset 3 (SEL 4'b1000, `DAT_O[31:24]`). On ACK, go to IDLE.
- **IDLE:** go to LSR_RD.
- **LSR_RD:** read offset 5 (SEL 4'b0010). On ACK, sample LSR = `DAT_I[15:8]`, then apply these in priority order:
  - DR (bit0) set and rx register empty: go to RHR_RD.
  - THRE (bit5) set and tx holding register full: go to THR_WR.
  - Otherwise: go to GAP.
- **GAP:** count `POLL_GAP` cycles, then go to IDLE.
- **RHR_RD:** read offset 0 (SEL 4'b0001). On ACK, load `rx_data` from `DAT_I[7:0]`, set `rx_valid`, and go to IDLE.
- **THR_WR:** write the held byte to offset 0 (SEL 4'b0001, `DAT_O[7:0]`). On ACK, empty the holding register and go to IDLE.
- **Transmit holding register (one entry):**
  - `tx_ready` = !full && state != INIT_WR.
  - A byte is accepted on `tx_valid && tx_ready`.
- **Receive output register:**
  - `rx_valid` holds until `rx_valid && rx_ready`.
  - An RHR read is never issued while `rx_valid` is high; this provides backpressure (UART overrun is the UART's concern).
- Unused `DAT_O` lanes are driven 0. `ADR_O`, `DAT_O`, `SEL_O` and `WE_O` are stable for the whole cycle.

## Timing
- **Reset values:** `CYC_O`/`STB_O`/`WE_O` 0; `ADR_O`, `DAT_O`, `SEL_O` 0; `tx_ready` 0; `rx_valid` 0; `rx_data` 0; `err` 0; holding register empty; state INIT_WR.
- **Bus cycle:** all bus outputs are registered.
  - STB/CYC rise the cycle after the state is entered.
  - ACK_I is sampled each edge while STB is high. On the ACK edge, STB/CYC drop in the next cycle.
  - Zero-wait slave: 2 clocks per access.
  - No pipelining and no back-to-back STB: at least one cycle of CYC low between accesses.
- **Latency:** tx byte accepted in IDLE with THRE set and zero-wait slave → THR write STB asserted 4 cycles later.
- **Simultaneous events:**
  - A tx accept while the holding register is being emptied is disallowed (`tx_ready` is low while full).
  - `rx_ready` consumption and the RHR ACK cannot coincide, because RHR_RD requires `rx_valid` low.
- **Reset mid-access:** on the next edge, STB/CYC drop and every register returns to its reset value. A held tx byte is lost. INIT_WR is repeated.
- ACK_I outside an active cycle is ignored.

## Configuration
- `UART_WBM_TIMEOUT_EN` defined:
  - An 8-bit-wide-enough counter runs while STB is high.
  - At `TIMEOUT_CYCLES` cycles without ACK: drop STB/CYC, pulse `err` for one cycle, and go to GAP.
  - The held tx byte is retained, and the aborted access is retried via the normal poll.
- Not defined: the master waits on ACK indefinitely, and `err` is tied 0.

## Structure
- **Shared package `uart_8250_pkg`:**
  - Register offsets: RHR_THR=0, IER=1, IIR_FCR=2, LCR=3, MCR=4, LSR=5, MSR=6.
  - LSR bit indices: LSR_DR=0, LSR_THRE=5.
  - The FSM state enum.
  - Shared by this block and `uart_8250`.
- **One sub-module `wb_single_access`:** issues one classic read or write given offset/data/we, and returns `done`, `rdata` and `timeout`. Lane steering and the timeout counter live there.

## Test plan
- **Init write:** after reset release, expect write ADR 32'h1250_0003, SEL 4'b1000, `DAT_O[31:24]`=8'h03, WE=1. Then the first LSR read at 32'h1250_0005.
- **Transmit:** send tx byte 8'h41 with the slave returning LSR=8'h20. Expect a write to 32'h1250_0000, SEL 4'b0001, `DAT_O[7:0]`=8'h41. `tx_ready` returns to 1 the cycle after ACK.
- **Receive:** slave returns LSR=8'h01 and RHR=8'h5A, `rx_ready`=1. Expect `rx_valid`=1 with `rx_data`=8'h5A, one cycle after the RHR ACK.
- **Priority and backpressure:**
  - LSR=8'h21 with tx byte pending: expect the RHR read before the THR write.
  - With `rx_valid` held (`rx_ready`=0): expect no RHR read, and the THR write proceeds.
- **Timeout (`UART_WBM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** slave never ACKs. Expect STB low after 8 cycles and a one-cycle `err` pulse. Polling then resumes after `POLL_GAP`.
- **Reset mid-access:** assert `RST_I` during a THR write with STB high. Expect STB/CYC=0 and `tx_ready`=0 on the next edge, then a fresh LCR write after release.
